handshake_cond_br_0: RTL



---
 rtl/handshake_cond_br_0_pkg.sv | 7 +
 rtl/handshake_cond_br_0_join.sv | 16 +
 rtl/handshake_cond_br_0.sv | 74 +++++++
 3 files changed

// File: rtl/handshake_cond_br_0_pkg.sv
// Shared constants for the registered conditional branch.
// Slot indices match the value of the condition token.
package handshake_cond_br_0_pkg;
    localparam int BR_FALSE  = 0;
    localparam int BR_TRUE   = 1;
    localparam int NUM_SLOTS = 2;
endpackage

// File: rtl/handshake_cond_br_0_join.sv
// N-way join: output valid when every input is valid;
// each input is ready when all other inputs are valid and the output is ready.
module join_type #(
    parameter int SIZE = 2
) (
    input  logic [SIZE-1:0] ins_valid,
    output logic [SIZE-1:0] ins_ready,
    output logic            outs_valid,
    input  logic            outs_ready
);
    assign outs_valid = &ins_valid;

    for (genvar i = 0; i < SIZE; i++) begin : g_rdy
        assign ins_ready[i] = outs_ready & (&(ins_valid | (SIZE'(1) << i)));
    end
endmodule

// File: rtl/handshake_cond_br_0.sv
// Registered conditional branch: joins condition and data, then steers the
// data into a one-slot buffer on the true or false output.
module handshake_cond_br_0
    import handshake_cond_br_0_pkg::*;
#(
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 condition,
    input  logic                 condition_valid,
    output logic                 condition_ready,
    input  logic [DATA_TYPE-1:0] data,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic [DATA_TYPE-1:0] trueOut,
    output logic                 trueOut_valid,
    input  logic                 trueOut_ready,
    output logic [DATA_TYPE-1:0] falseOut,
    output logic                 falseOut_valid,
    input  logic                 falseOut_ready
);
    logic                 full      [NUM_SLOTS];
    logic [DATA_TYPE-1:0] slot_data [NUM_SLOTS];
    logic                 out_ready [NUM_SLOTS];
    logic                 load      [NUM_SLOTS];
    logic [1:0]           ins_valid;
    logic [1:0]           ins_ready;
    logic                 join_valid;
    logic                 load_ok_sel;
    logic                 fire;

    assign out_ready[BR_TRUE]  = trueOut_ready;
    assign out_ready[BR_FALSE] = falseOut_ready;

    // Pipeline mode: a full slot can accept if it drains in the same cycle.
    assign load_ok_sel = !full[condition] || out_ready[condition];

    assign ins_valid = {data_valid, condition_valid};

    join_type #(
        .SIZE(2)
    ) u_join (
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .outs_valid(join_valid),
        .outs_ready(load_ok_sel)
    );

    assign condition_ready = ins_ready[0];
    assign data_ready      = ins_ready[1];
    assign fire            = join_valid & load_ok_sel;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign load[i] = fire && (condition == 1'(i));

        always_ff @(posedge clk) begin
            if (rst) begin
                full[i]      <= 1'b0;
                slot_data[i] <= '0;
            end else if (load[i]) begin
                full[i]      <= 1'b1;
                slot_data[i] <= data;
            end else if (full[i] && out_ready[i]) begin
                full[i]      <= 1'b0;
            end
        end
    end

    assign trueOut        = slot_data[BR_TRUE];
    assign trueOut_valid  = full[BR_TRUE];
    assign falseOut       = slot_data[BR_FALSE];
    assign falseOut_valid = full[BR_FALSE];
endmodule
